// File: rtl/wb_stage_traceq.sv
// Writeback stage with a registered retire-trace queue.
// Define WB_RETIRE_CNT_EN to add the retire_cnt port and counter.
module wb_stage_traceq #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int PC_W     = 32,
  parameter int TQ_DEPTH = 4,
  localparam int BUS_W   = 1 + ADDR_W + DATA_W + PC_W,
  localparam int PTR_W   = $clog2(TQ_DEPTH),
  localparam int LVL_W   = PTR_W + 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       mem_valid,
  input  logic [BUS_W-1:0]           mem_bus,
  output logic                       wb_allow_in,
  output logic                       rf_wen,
  output logic [ADDR_W-1:0]          rf_waddr,
  output logic [DATA_W-1:0]          rf_wdata,
  output logic [1+ADDR_W+DATA_W:0]   fwd_bus,
  output logic                       trace_valid,
  input  logic                       trace_ready,
  output logic [BUS_W-1:0]           trace_data,
  output logic [LVL_W-1:0]           tq_level
`ifdef WB_RETIRE_CNT_EN
  ,
  output logic [31:0]                retire_cnt
`endif
);

  logic             wb_valid_q;
  logic             wb_valid_d;
  logic [BUS_W-1:0] wb_bus_q;

  logic [BUS_W-1:0] tq_mem_q [TQ_DEPTH];
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W-1:0] rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] wr_ptr_d;
  logic [LVL_W-1:0] lvl_q;
  logic [LVL_W-1:0] lvl_d;

  logic              wb_wen;
  logic [ADDR_W-1:0] wb_waddr;
  logic [DATA_W-1:0] wb_res;
  logic              tq_full;
  logic              tq_empty;
  logic              pop;
  logic              push;
  logic              wb_ready;
  logic              retire;

  assign wb_wen   = wb_bus_q[BUS_W-1];
  assign wb_waddr = wb_bus_q[BUS_W-2 -: ADDR_W];
  assign wb_res   = wb_bus_q[PC_W +: DATA_W];

  assign tq_full  = (lvl_q == LVL_W'(TQ_DEPTH));
  assign tq_empty = (lvl_q == '0);

  // Reset masks all outward strobes so stale state never leaks out.
  assign trace_valid = !tq_empty && !rst;
  assign pop         = trace_valid && trace_ready;
  assign wb_ready    = !tq_full || pop;
  assign retire      = wb_valid_q && wb_ready && !rst;
  assign push        = retire;

  assign wb_allow_in = !wb_valid_q || wb_ready || rst;

  assign rf_wen   = retire && wb_wen;
  assign rf_waddr = wb_waddr;
  assign rf_wdata = wb_res;

  assign fwd_bus = {wb_valid_q && !rst,
                    wb_valid_q && wb_wen && !rst,
                    wb_waddr,
                    wb_res};

  assign trace_data = tq_mem_q[rd_ptr_q];
  assign tq_level   = lvl_q;

  always_comb begin
    wb_valid_d = wb_valid_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    lvl_d      = lvl_q;
    if (wb_allow_in) begin
      wb_valid_d = mem_valid;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    unique case ({push, pop})
      2'b10:   lvl_d = lvl_q + LVL_W'(1);
      2'b01:   lvl_d = lvl_q - LVL_W'(1);
      default: lvl_d = lvl_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wb_valid_q <= 1'b0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      lvl_q      <= '0;
    end else begin
      wb_valid_q <= wb_valid_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      lvl_q      <= lvl_d;
    end
  end

  // Payload storage carries no reset; validity lives in the control regs.
  always_ff @(posedge clk) begin
    if (mem_valid && wb_allow_in) begin
      wb_bus_q <= mem_bus;
    end
    if (push) begin
      tq_mem_q[wr_ptr_q] <= wb_bus_q;
    end
  end

`ifdef WB_RETIRE_CNT_EN
  logic [31:0] retire_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      retire_cnt_q <= '0;
    end else if (retire) begin
      retire_cnt_q <= retire_cnt_q + 32'd1;
    end
  end

  assign retire_cnt = retire_cnt_q;
`endif

endmodule

// File: tb/tb_wb_stage_traceq.sv
// Directed bench for wb_stage_traceq.
// Build with WB_RETIRE_CNT_EN to also exercise the retire counter.
module tb_wb_stage_traceq;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int PC_W   = 32;
  localparam int BUS_W  = 1 + ADDR_W + DATA_W + PC_W;
  localparam int FWD_W  = 2 + ADDR_W + DATA_W;

  logic              clk = 1'b0;
  logic              rst;
  logic              mem_valid;
  logic [BUS_W-1:0]  mem_bus;
  logic              wb_allow_in;
  logic              rf_wen;
  logic [ADDR_W-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic [FWD_W-1:0]  fwd_bus;
  logic              trace_valid;
  logic              trace_ready;
  logic [BUS_W-1:0]  trace_data;
  logic [2:0]        tq_level;
`ifdef WB_RETIRE_CNT_EN
  logic [31:0]       retire_cnt;
`endif

  wb_stage_traceq dut (
    .clk         (clk),
    .rst         (rst),
    .mem_valid   (mem_valid),
    .mem_bus     (mem_bus),
    .wb_allow_in (wb_allow_in),
    .rf_wen      (rf_wen),
    .rf_waddr    (rf_waddr),
    .rf_wdata    (rf_wdata),
    .fwd_bus     (fwd_bus),
    .trace_valid (trace_valid),
    .trace_ready (trace_ready),
    .trace_data  (trace_data),
    .tq_level    (tq_level)
`ifdef WB_RETIRE_CNT_EN
    ,
    .retire_cnt  (retire_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(string tag, logic [127:0] obs, logic [127:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [BUS_W-1:0] mk(logic w, logic [4:0] a,
                                          logic [31:0] r, logic [31:0] p);
    return {w, a, r, p};
  endfunction

  int               wr_cnt = 0;
  logic [BUS_W-1:0] got [$];

  always @(negedge clk) begin
    if (rf_wen) wr_cnt++;
    if (trace_valid && trace_ready) got.push_back(trace_data);
  end

  logic [BUS_W-1:0] vec [8];
  int               idx;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic feed(int ncyc, int nmax);
    logic acc;
    for (int c = 0; c < ncyc; c++) begin
      if (idx < nmax) begin
        mem_valid = 1'b1;
        mem_bus   = vec[idx];
      end else begin
        mem_valid = 1'b0;
      end
      #1;
      acc = mem_valid && wb_allow_in;
      tick();
      if (acc) idx++;
    end
  endtask

  int w0;
  int g0;
  logic [BUS_W-1:0] b;

  initial begin
    rst         = 1'b1;
    mem_valid   = 1'b0;
    mem_bus     = '0;
    trace_ready = 1'b0;
    tick();
    tick();
    chk("rst_tvalid", trace_valid, 0);
    chk("rst_rfwen", rf_wen, 0);
    chk("rst_allow", wb_allow_in, 1);
    chk("rst_fwdv", fwd_bus[FWD_W-1], 0);
    chk("rst_level", tq_level, 0);
    rst = 1'b0;
    tick();
    chk("post_rst_allow", wb_allow_in, 1);
    chk("post_rst_tvalid", trace_valid, 0);

    // single instruction
    trace_ready = 1'b1;
    b = mk(1'b1, 5'd5, 32'h1234, 32'h100);
    mem_valid = 1'b1;
    mem_bus   = b;
    #1;
    chk("t1_allow", wb_allow_in, 1);
    tick();
    mem_valid = 1'b0;
    #1;
    chk("t1_rfwen", rf_wen, 1);
    chk("t1_waddr", rf_waddr, 5);
    chk("t1_wdata", rf_wdata, 32'h1234);
    chk("t1_tvalid_n1", trace_valid, 0);
    chk("t1_fwd_wen", fwd_bus[FWD_W-2], 1);
    tick();
    chk("t1_rfwen_n2", rf_wen, 0);
    chk("t1_tvalid_n2", trace_valid, 1);
    chk("t1_tpc", trace_data[31:0], 32'h100);
    chk("t1_tdata", trace_data, b);
    tick();
    chk("t1_level", tq_level, 0);

    // wen=0 still traced
    b = mk(1'b0, 5'd7, 32'hBEEF, 32'h104);
    mem_valid = 1'b1;
    mem_bus   = b;
    tick();
    mem_valid = 1'b0;
    #1;
    chk("t2_rfwen", rf_wen, 0);
    chk("t2_fwd_v", fwd_bus[FWD_W-1], 1);
    chk("t2_fwd_wen", fwd_bus[FWD_W-2], 0);
    chk("t2_fwd_res", fwd_bus[31:0], 32'hBEEF);
    tick();
    chk("t2_tvalid", trace_valid, 1);
    chk("t2_tdata", trace_data, b);
    tick();
    chk("t2_level", tq_level, 0);

    // 8-deep stream against a stalled trace port
    for (int i = 0; i < 8; i++) begin
      vec[i] = mk(1'b1, 5'(i + 1), 32'h100 + 32'(i), 32'h200 + 32'(4 * i));
    end
    trace_ready = 1'b0;
    idx = 0;
    w0  = wr_cnt;
    g0  = got.size();
    feed(8, 8);
    chk("s_accepted", idx, 5);
    chk("s_writes", wr_cnt - w0, 4);
    chk("s_level", tq_level, 4);
    chk("s_allow", wb_allow_in, 0);
    chk("s_rfwen", rf_wen, 0);
    chk("s_held_v", fwd_bus[FWD_W-1], 1);
    chk("s_held_res", fwd_bus[31:0], 32'h104);
    chk("s_head", trace_data, vec[0]);

    // full queue, held instruction, pop+push in one cycle
    trace_ready = 1'b1;
    #1;
    chk("f_rfwen", rf_wen, 1);
    chk("f_waddr", rf_waddr, 5);
    chk("f_allow", wb_allow_in, 1);
    tick();
    idx++;
    chk("f_level", tq_level, 4);
    chk("f_writes", wr_cnt - w0, 5);
    feed(20, 8);
    mem_valid = 1'b0;
    chk("d_count", got.size() - g0, 8);
    chk("d_writes", wr_cnt - w0, 8);
    chk("d_level", tq_level, 0);
    if (got.size() - g0 == 8) begin
      for (int k = 0; k < 8; k++) begin
        chk($sformatf("d_order%0d", k), got[g0 + k], vec[k]);
      end
    end

    // reset while three entries queued and WB holds one
    trace_ready = 1'b0;
    idx = 0;
    feed(4, 4);
    mem_valid = 1'b0;
    chk("r_pre_level", tq_level, 3);
    chk("r_pre_held", fwd_bus[FWD_W-1], 1);
    w0  = wr_cnt;
    rst = 1'b1;
    #1;
    chk("r_rfwen", rf_wen, 0);
    chk("r_tvalid", trace_valid, 0);
    chk("r_allow", wb_allow_in, 1);
    tick();
    rst = 1'b0;
    #1;
    chk("r_level", tq_level, 0);
    chk("r_tvalid_after", trace_valid, 0);
    chk("r_rfwen_after", rf_wen, 0);
    chk("r_fwdv_after", fwd_bus[FWD_W-1], 0);
    chk("r_no_write", wr_cnt - w0, 0);
    tick();
    chk("r_allow_after", wb_allow_in, 1);

`ifdef WB_RETIRE_CNT_EN
    chk("c_zero", retire_cnt, 0);
    force dut.retire_cnt_q = 32'hFFFF_FFFE;
    #1;
    release dut.retire_cnt_q;
    trace_ready = 1'b1;
    idx = 0;
    feed(5, 3);
    chk("c_wrap", retire_cnt, 1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_stage_traceq.md
WB_STAGE_TRACEQ -- requirements
Module: wb_stage_traceq

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, meaning the register-file write-data and result width.
REQ-002 The block SHALL have parameter ADDR_W, default 5, meaning the register-file address width.
REQ-003 The block SHALL have parameter PC_W, default 32, meaning the PC width.
REQ-004 The block SHALL have parameter TQ_DEPTH, default 4, meaning the trace-queue entries; it is a power of two and at least 2.
REQ-005 The block SHALL define local BUS_W = 1+ADDR_W+DATA_W+PC_W.
REQ-006 The block SHALL have port clk, input, 1 bit: clock; all state updates on posedge.
REQ-007 The block SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-008 The block SHALL have port mem_valid, input, 1 bit: the upstream MEM stage holds a valid instruction.
REQ-009 The block SHALL have port mem_bus, input, BUS_W bits: {wen, waddr, result, pc}, MSB first.
REQ-010 The block SHALL have port wb_allow_in, output, 1 bit: the stage accepts mem_bus this cycle.
REQ-011 The block SHALL have ports rf_wen (output, 1 bit), rf_waddr (output, ADDR_W bits) and rf_wdata (output, DATA_W bits): the register-file write port.
REQ-012 The block SHALL have port fwd_bus, output, 2+ADDR_W+DATA_W bits: {wb_valid, wb_valid&wen, waddr, result}, used for ID bypass.
REQ-013 The block SHALL have ports trace_valid (output, 1 bit), trace_ready (input, 1 bit) and trace_data (output, BUS_W bits): the retire-trace stream.
REQ-014 The block SHALL have port tq_level, output, log2(TQ_DEPTH)+1 bits: the trace-queue occupancy.
REQ-015 The block SHALL have port retire_cnt, output, 32 bits: the retired-instruction count; this port is present only with WB_RETIRE_CNT_EN.

Function
REQ-016 The block SHALL hold one stage register (wb_valid, wb_bus) and load it with mem_bus when mem_valid & wb_allow_in.
REQ-017 wb_valid SHALL load mem_valid whenever wb_allow_in=1 and otherwise hold its value.
REQ-018 wb_ready SHALL be !tq_full | (trace_valid & trace_ready), a combinational path from trace_ready.
REQ-019 wb_allow_in SHALL equal !wb_valid | wb_ready.
REQ-020 An instruction SHALL retire in the cycle wb_valid & wb_ready; no other cycle is a retire cycle.
REQ-021 rf_wen SHALL equal wb_valid & wb_ready & wen, so each instruction writes the register file exactly once, even under stall.
REQ-022 rf_waddr and rf_wdata SHALL follow wb_bus combinationally.
REQ-023 Each retiring instruction SHALL push wb_bus into the trace queue, in order, in its retire cycle.
REQ-024 The trace queue SHALL be a registered FIFO with no fall-through: an instruction pushed in cycle N is visible on trace_valid/trace_data in cycle N+1 at the earliest.
REQ-025 A pop SHALL occur when trace_valid & trace_ready, and trace_data SHALL be stable while trace_valid=1 and trace_ready=0.
REQ-026 Simultaneous push and pop SHALL leave tq_level unchanged, including when the queue is full.
REQ-027 Read and write pointers SHALL wrap modulo TQ_DEPTH, and full/empty SHALL be derived from tq_level.
REQ-028 Minimum latency SHALL be: accept in cycle N, RF write in N+1, trace_valid in N+2; throughput is 1 per cycle while trace_ready=1.
REQ-029 A bubble (wb_valid=0) SHALL cause no push, no RF write and no counter increment.

Reset
REQ-030 On rst, the block SHALL force wb_valid=0, both queue pointers=0, tq_level=0 and retire_cnt=0.
REQ-031 During and immediately after reset, the outputs SHALL be: trace_valid=0, rf_wen=0, wb_allow_in=1 and fwd_bus MSB=0.
REQ-032 Reset SHALL NOT clear wb_bus or the queue storage.
REQ-033 A reset asserted mid-stall SHALL discard all queued entries and the held instruction without an RF write.

Configuration
REQ-034 With macro WB_RETIRE_CNT_EN defined, retire_cnt SHALL increment by 1 per retire cycle and wrap from 0xFFFFFFFF to 0.
REQ-035 Without WB_RETIRE_CNT_EN, the retire_cnt port and counter SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-036 Reset then a single instruction {wen=1, waddr=5, result=0x1234, pc=0x100} with trace_ready=1 -> rf_wen pulses 1 cycle with addr 5/data 0x1234 at N+1; trace_valid at N+2 with pc 0x100; tq_level returns to 0.
REQ-037 Stream 8 back-to-back instructions with trace_ready=0 and TQ_DEPTH=4 -> 4 RF writes, tq_level=4, wb_allow_in=0, the 5th held in WB with rf_wen=0; raising trace_ready drains all 8 in order.
REQ-038 Queue full with wb_valid=1 and trace_ready=1 -> same-cycle pop and push, tq_level stays 4, a single RF write.
REQ-039 Instruction with wen=0 -> no rf_wen, but it is still traced; fwd_bus bit for wen is 0.
REQ-040 rst asserted with tq_level=3 and WB held -> next cycle tq_level=0, trace_valid=0, no RF write for the held instruction.
REQ-041 With WB_RETIRE_CNT_EN and the counter preloaded via force to 0xFFFFFFFE, 3 retires -> retire_cnt=1.
